// File: rtl/sum_window_reader_pkg.sv
// Shared definitions for the sum window reader: FSM state encoding and
// overrun counter width.
package sum_window_reader_pkg;

  // Reader sequencing: wait for a window edge, capture, scale, hold result
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    SCALE = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // Width of the saturating overrun counter
  localparam int OVR_BITS = 8;

endpackage

// File: rtl/sum_window_reader_sat_shift.sv
// Combinational arithmetic right shift with saturation to a narrower signed
// width. The shift amount is clamped to IN_BITS-1.
// Optional feature: define SUM_READER_ROUND_EN to round half up before the
// shift; without it the shift truncates toward negative infinity.
module sat_shift
  import sum_window_reader_pkg::*;
#(
  parameter int IN_BITS  = 32,
  parameter int OUT_BITS = 16
) (
  input  logic signed [IN_BITS-1:0]  val_i,
  input  logic        [5:0]          shift_i,
  output logic signed [OUT_BITS-1:0] res_o,
  output logic                       sat_o
);

  // One extra bit so the rounding increment can never wrap the sum
  localparam int WIDE = IN_BITS + 1;
  localparam logic [5:0] MAX_SH = 6'(IN_BITS - 1);

  logic        [5:0]          sh;
  logic signed [WIDE-1:0]     round_inc;
  logic signed [WIDE-1:0]     wide;
  logic signed [WIDE-1:0]     shifted;
  logic        [WIDE-OUT_BITS:0] upper;

  // Clamp, optionally round, shift, then clip when the upper bits are not
  // all copies of the sign bit
  always_comb begin
    sh = (shift_i > MAX_SH) ? MAX_SH : shift_i;
    round_inc = '0;
`ifdef SUM_READER_ROUND_EN
    if (sh != 6'd0) round_inc = WIDE'(1) << (sh - 6'd1);
`else
    round_inc = '0;
`endif
    wide    = {val_i[IN_BITS-1], val_i} + round_inc;
    shifted = wide >>> sh;
    upper   = shifted[WIDE-1:OUT_BITS-1];
    sat_o   = !((&upper) || (~|upper));
    if (!sat_o)
      res_o = shifted[OUT_BITS-1:0];
    else if (shifted[WIDE-1])
      res_o = {1'b1, {(OUT_BITS-1){1'b0}}};
    else
      res_o = {1'b0, {(OUT_BITS-1){1'b1}}};
  end

endmodule

// File: rtl/sum_window_reader.sv
// Reads the upstream window sum one cycle after each cnt_timer rising edge,
// scales it by an arithmetic right shift, saturates it and presents it with
// a valid/ready handshake. Results replaced before acceptance are counted.
// Optional feature: SUM_READER_ROUND_EN (round half up, see sat_shift).
module sum_window_reader
  import sum_window_reader_pkg::*;
#(
  parameter int DAT_BITS = 16,
  parameter int CNT_BITS = 16,
  parameter int OUT_BITS = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic signed [DAT_BITS+CNT_BITS-1:0] sum_in,
  input  logic                             cnt_timer,
  input  logic        [5:0]                shift_amt,
  output logic        [OUT_BITS-1:0]       avg_out,
  output logic                             avg_valid,
  input  logic                             avg_ready,
  output logic                             sat_flag,
  output logic        [7:0]                overrun_cnt
);

  localparam int SUM_BITS = DAT_BITS + CNT_BITS;

  state_t                      state_q, state_d;
  logic                        cnt_timer_q;
  logic signed [SUM_BITS-1:0]  sum_q;
  logic        [5:0]           shift_q;
  logic signed [OUT_BITS-1:0]  avg_q;
  logic                        sat_q;
  logic                        valid_q, valid_d;
  logic        [OVR_BITS-1:0]  ovr_q, ovr_d;
  logic                        capture_en;
  logic                        load_en;
  logic                        edge_det;
  logic signed [OUT_BITS-1:0]  scaled;
  logic                        scaled_sat;

  assign edge_det    = cnt_timer & ~cnt_timer_q;
  assign avg_out     = avg_q;
  assign avg_valid   = valid_q;
  assign sat_flag    = sat_q;
  assign overrun_cnt = ovr_q;

  sat_shift #(
    .IN_BITS  (SUM_BITS),
    .OUT_BITS (OUT_BITS)
  ) u_sat_shift (
    .val_i   (sum_q),
    .shift_i (shift_q),
    .res_o   (scaled),
    .sat_o   (scaled_sat)
  );

  // Next state, valid flag and overrun count; edges in ARM/SCALE are ignored
  always_comb begin
    state_d    = state_q;
    valid_d    = valid_q;
    ovr_d      = ovr_q;
    capture_en = 1'b0;
    load_en    = 1'b0;
    if (valid_q && avg_ready) valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (edge_det) state_d = ARM;
      end
      ARM: begin
        capture_en = 1'b1;
        state_d    = SCALE;
      end
      SCALE: begin
        load_en = 1'b1;
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (valid_q && avg_ready) begin
          state_d = edge_det ? ARM : IDLE;
        end else if (edge_det) begin
          state_d = ARM;
          if (ovr_q != {OVR_BITS{1'b1}}) ovr_d = ovr_q + OVR_BITS'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state, handshake flag, overrun counter and timer edge history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      ovr_q       <= '0;
      cnt_timer_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      ovr_q       <= ovr_d;
      cnt_timer_q <= cnt_timer;
    end
  end

  // Capture the settled sum in ARM and load the scaled result in SCALE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q   <= '0;
      shift_q <= '0;
      avg_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      if (capture_en) begin
        sum_q   <= sum_in;
        shift_q <= shift_amt;
      end
      if (load_en) begin
        avg_q <= scaled;
        sat_q <= scaled_sat;
      end
    end
  end

endmodule

// File: tb/tb_sum_window_reader.sv
// Directed bench for sum_window_reader with hand-computed expectations.
// Expected rounding results follow SUM_READER_ROUND_EN when defined.
module tb_sum_window_reader;

  logic        clk;
  logic        rst;
  logic [31:0] sum_in;
  logic        cnt_timer;
  logic [5:0]  shift_amt;
  logic [15:0] avg_out;
  logic        avg_valid;
  logic        avg_ready;
  logic        sat_flag;
  logic [7:0]  overrun_cnt;

  int checks;
  int failures;

  sum_window_reader #(
    .DAT_BITS (16),
    .CNT_BITS (16),
    .OUT_BITS (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sum_in      (sum_in),
    .cnt_timer   (cnt_timer),
    .shift_amt   (shift_amt),
    .avg_out     (avg_out),
    .avg_valid   (avg_valid),
    .avg_ready   (avg_ready),
    .sat_flag    (sat_flag),
    .overrun_cnt (overrun_cnt)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task tick();
    @(posedge clk);
    #1;
  endtask

  // One window: edge, capture on ARM, result valid after the SCALE edge
  task window(input logic [31:0] s, input logic [5:0] sh);
    sum_in    = s;
    shift_amt = sh;
    cnt_timer = 1'b1;
    tick();
    tick();
    cnt_timer = 1'b0;
    tick();
  endtask

  task accept();
    avg_ready = 1'b1;
    tick();
    avg_ready = 1'b0;
  endtask

  task do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task check_result(input string name, input logic [15:0] exp_out,
                    input logic exp_sat, input logic exp_valid);
    checks++;
    if (avg_out !== exp_out) begin
      $display("[TB] FAIL %s avg_out got %h expected %h", name, avg_out, exp_out);
      failures++;
    end
    checks++;
    if (sat_flag !== exp_sat) begin
      $display("[TB] FAIL %s sat_flag got %b expected %b", name, sat_flag, exp_sat);
      failures++;
    end
    checks++;
    if (avg_valid !== exp_valid) begin
      $display("[TB] FAIL %s avg_valid got %b expected %b", name, avg_valid, exp_valid);
      failures++;
    end
  endtask

  task check_ovr(input string name, input logic [7:0] exp_ovr);
    checks++;
    if (overrun_cnt !== exp_ovr) begin
      $display("[TB] FAIL %s overrun_cnt got %0d expected %0d", name, overrun_cnt, exp_ovr);
      failures++;
    end
  endtask

  task test_reset();
    do_reset();
    check_result("reset", 16'h0000, 1'b0, 1'b0);
    check_ovr("reset", 8'd0);
  endtask

  task test_latency();
    sum_in    = 32'h0001_0000;
    shift_amt = 6'd16;
    cnt_timer = 1'b1;
    tick();
    check_result("lat_arm", 16'h0000, 1'b0, 1'b0);
    tick();
    check_result("lat_scale", 16'h0000, 1'b0, 1'b0);
    cnt_timer = 1'b0;
    tick();
    check_result("lat_hold", 16'h0001, 1'b0, 1'b1);
    accept();
    check_result("lat_accept", 16'h0001, 1'b0, 1'b0);
    check_ovr("lat", 8'd0);
  endtask

  task test_saturation();
    window(32'h7FFF_FFFF, 6'd0);
    check_result("sat_pos", 16'h7FFF, 1'b1, 1'b1);
    accept();
    window(32'h8000_0000, 6'd0);
    check_result("sat_neg", 16'h8000, 1'b1, 1'b1);
    accept();
    window(32'h8000_0000, 6'd63);
    check_result("clamp_neg", 16'hFFFF, 1'b0, 1'b1);
    accept();
`ifdef SUM_READER_ROUND_EN
    window(32'h7FFF_FFFF, 6'd63);
    check_result("clamp_pos", 16'h0001, 1'b0, 1'b1);
`else
    window(32'h7FFF_FFFF, 6'd63);
    check_result("clamp_pos", 16'h0000, 1'b0, 1'b1);
`endif
    accept();
  endtask

  task test_rounding();
`ifdef SUM_READER_ROUND_EN
    window(32'h0000_0003, 6'd1);
    check_result("round_pos", 16'h0002, 1'b0, 1'b1);
    accept();
    window(32'hFFFF_FFFB, 6'd1);
    check_result("round_neg", 16'hFFFE, 1'b0, 1'b1);
`else
    window(32'h0000_0003, 6'd1);
    check_result("round_pos", 16'h0001, 1'b0, 1'b1);
    accept();
    window(32'hFFFF_FFFB, 6'd1);
    check_result("round_neg", 16'hFFFD, 1'b0, 1'b1);
`endif
    accept();
  endtask

  task test_overrun();
    window(32'h0000_0100, 6'd4);
    check_result("ovr_w1", 16'd16, 1'b0, 1'b1);
    window(32'h0000_0200, 6'd4);
    check_result("ovr_w2", 16'd32, 1'b0, 1'b1);
    check_ovr("ovr_w2", 8'd1);
    sum_in    = 32'h0000_0300;
    cnt_timer = 1'b1;
    tick();
    check_result("ovr_w3_arm", 16'd32, 1'b0, 1'b1);
    tick();
    cnt_timer = 1'b0;
    tick();
    check_result("ovr_w3", 16'd48, 1'b0, 1'b1);
    check_ovr("ovr_w3", 8'd2);
    for (int i = 0; i < 256; i++) window(32'h0000_0010, 6'd4);
    check_ovr("ovr_saturate", 8'd255);
    check_result("ovr_saturate", 16'd1, 1'b0, 1'b1);
  endtask

  task test_reset_mid();
    sum_in    = 32'h0009_0000;
    shift_amt = 6'd16;
    cnt_timer = 1'b1;
    tick();
    tick();
    #2;
    rst = 1'b1;
    #1;
    check_result("rst_mid", 16'h0000, 1'b0, 1'b0);
    check_ovr("rst_mid", 8'd0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
    check_result("rst_no_edge", 16'h0000, 1'b0, 1'b0);
    cnt_timer = 1'b0;
    tick();
    window(32'h0005_0000, 6'd16);
    check_result("rst_recover", 16'h0005, 1'b0, 1'b1);
    check_ovr("rst_recover", 8'd0);
  endtask

  task test_back_to_back();
    sum_in    = 32'h0007_0000;
    shift_amt = 6'd16;
    avg_ready = 1'b1;
    cnt_timer = 1'b1;
    tick();
    avg_ready = 1'b0;
    check_result("b2b_accept", 16'h0005, 1'b0, 1'b0);
    check_ovr("b2b_accept", 8'd0);
    tick();
    cnt_timer = 1'b0;
    tick();
    check_result("b2b_new", 16'h0007, 1'b0, 1'b1);
    check_ovr("b2b_new", 8'd0);
    accept();
  endtask

  // Run all scenarios in order and report
  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    sum_in    = '0;
    cnt_timer = 1'b0;
    shift_amt = '0;
    avg_ready = 1'b0;
    test_reset();
    test_latency();
    test_saturation();
    test_rounding();
    do_reset();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
